axis_img_streamer: RTL and testbench

- Transmit side of the classifier stream link: holds one image of NUMBER_OF_INPUT_WORDS words and streams it as one AXI4-Stream packet (TLAST on the final word) into the accelerator wrapper's slave port.
- Then accepts the single result word returned on its own slave port.
- Sits between the host-side loader and the accelerator top; also serves as the bench/board traffic source for classifier bring-up.

---
 rtl/axis_img_streamer_pkg.sv | 16 +
 rtl/img_word_buffer.sv | 25 ++
 rtl/axis_img_streamer.sv | 107 ++++++++++
 tb/tb_axis_img_streamer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_img_streamer_pkg.sv
// axis_img_streamer_pkg: shared state encoding, counter widths and the clogb2 helper.
package axis_img_streamer_pkg;
  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    SEND        = 2'b01,
    WAIT_RESULT = 2'b10
  } state_t;
  localparam int RESULT_COUNT_W = 16;
  function automatic int clogb2(input int value);
    int n;
    int v;
    n = 0;
    for (v = value; v > 0; v = v >> 1) n++;
    return (n == 0) ? 1 : n;
  endfunction
endpackage

// File: rtl/img_word_buffer.sv
// img_word_buffer: NUMBER_OF_INPUT_WORDS x DATA_WIDTH register array, one write port and one registered read port.
// Ports: axi_clk/axi_reset_n clock and sync active-low reset (read register only);
//        wren/waddr/wdata write port; rden/raddr read request; rdata registered read word.
module img_word_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_OF_INPUT_WORDS = 32,
  parameter int AW = 5
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  wren,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rden,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [NUMBER_OF_INPUT_WORDS];
  always_ff @(posedge axi_clk)
    if (wren) mem[waddr] <= wdata;
  // A write and a read of the same word in one cycle returns the new word.
  always_ff @(posedge axi_clk)
    if (!axi_reset_n) rdata <= '0;
    else if (rden) rdata <= (wren && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/axis_img_streamer.sv
// axis_img_streamer: buffers one image, streams it as one AXI4-Stream packet, then captures one result word.
// Ports: axi_clk, axi_reset_n (sync active-low); ld_wren/ld_addr/ld_data image load (IDLE only);
//        start send request (IDLE only); m_axis_* TX packet; s_axis_* result input;
//        busy, result, result_valid, proto_err, timeout, result_count status.
// Optional: AXIS_IMG_STREAMER_TIMEOUT_EN adds a TIMEOUT_CYCLES limit on the result wait.
module axis_img_streamer
  import axis_img_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_OF_INPUT_WORDS = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                         axi_clk,
  input  logic                                         axi_reset_n,
  input  logic                                         ld_wren,
  input  logic [clogb2(NUMBER_OF_INPUT_WORDS-1)-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]                        ld_data,
  input  logic                                         start,
  output logic                                         m_axis_valid,
  output logic [DATA_WIDTH-1:0]                        m_axis_data,
  output logic                                         m_axis_last,
  input  logic                                         m_axis_ready,
  input  logic                                         s_axis_valid,
  input  logic [DATA_WIDTH-1:0]                        s_axis_data,
  input  logic                                         s_axis_last,
  output logic                                         s_axis_ready,
  output logic                                         busy,
  output logic [DATA_WIDTH-1:0]                        result,
  output logic                                         result_valid,
  output logic                                         proto_err,
  output logic                                         timeout,
  output logic [RESULT_COUNT_W-1:0]                    result_count
);
  localparam int AW = clogb2(NUMBER_OF_INPUT_WORDS-1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUMBER_OF_INPUT_WORDS-1);
  state_t state, state_d;
  logic [AW-1:0] ptr, raddr;
  logic beat, hs, go, wr, rden, expire;
  assign beat = m_axis_valid && m_axis_ready;
  assign hs = s_axis_valid && s_axis_ready;
  assign go = (state == IDLE) && start;
  assign wr = (state == IDLE) && ld_wren;
  assign m_axis_valid = state == SEND;
  assign m_axis_last = m_axis_valid && ptr == LAST_IDX;
  assign s_axis_ready = state == WAIT_RESULT;
  assign busy = state != IDLE;
  // ptr names the word on the bus; the buffer is asked for the next one as soon as
  // the current beat is taken, so ready-high streaming never bubbles.
  assign rden = go || (beat && !m_axis_last);
  assign raddr = go ? '0 : ptr + 1'b1;
  img_word_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUMBER_OF_INPUT_WORDS(NUMBER_OF_INPUT_WORDS),
    .AW(AW)
  ) u_buf (
    .axi_clk(axi_clk),
    .axi_reset_n(axi_reset_n),
    .wren(wr),
    .waddr(ld_addr),
    .wdata(ld_data),
    .rden(rden),
    .raddr(raddr),
    .rdata(m_axis_data)
  );
`ifdef AXIS_IMG_STREAMER_TIMEOUT_EN
  localparam int TW = clogb2(TIMEOUT_CYCLES-1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge axi_clk)
    if (!axi_reset_n || state != WAIT_RESULT) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  assign expire = s_axis_ready && !hs && tcnt == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge axi_clk)
    if (!axi_reset_n) timeout <= 1'b0;
    else timeout <= expire;
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:        if (start) state_d = SEND;
      SEND:        if (beat && m_axis_last) state_d = WAIT_RESULT;
      WAIT_RESULT: if (hs || expire) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state <= IDLE;
      ptr <= '0;
      result <= '0;
      result_valid <= 1'b0;
      proto_err <= 1'b0;
      result_count <= '0;
    end else begin
      state <= state_d;
      ptr <= go ? '0 : beat ? ptr + 1'b1 : ptr;
      result_valid <= hs;
      proto_err <= go ? 1'b0 : proto_err | (hs && !s_axis_last);
      if (hs) begin
        result <= s_axis_data;
        result_count <= result_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_img_streamer.sv
// tb_axis_img_streamer: scoreboard bench; expected beats/results are queued at stimulus time and popped by a monitor.
module tb_axis_img_streamer;
  localparam int DW = 32;
  localparam int N = 32;
  localparam int T = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ld_wren = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic start = 1'b0;
  logic m_valid, m_last, s_ready, busy, result_valid, proto_err, timeout;
  logic [DW-1:0] m_data, result;
  logic m_ready = 1'b0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_last = 1'b0;
  logic [15:0] result_count;

  always #5 clk = ~clk;

  axis_img_streamer #(
    .DATA_WIDTH(DW),
    .NUMBER_OF_INPUT_WORDS(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .axi_clk(clk),
    .axi_reset_n(rst_n),
    .ld_wren(ld_wren),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .start(start),
    .m_axis_valid(m_valid),
    .m_axis_data(m_data),
    .m_axis_last(m_last),
    .m_axis_ready(m_ready),
    .s_axis_valid(s_valid),
    .s_axis_data(s_data),
    .s_axis_last(s_last),
    .s_axis_ready(s_ready),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .proto_err(proto_err),
    .timeout(timeout),
    .result_count(result_count)
  );

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [DW-1:0] d; logic perr; logic [15:0] cnt;} res_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] img [N];
  beat_t exp_q[$];
  res_t res_q[$];
  logic perr_m = 1'b0;
  logic [15:0] cnt_m = '0;
  logic [DW-1:0] res_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat or a result.
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  beat_t eb;
  res_t er;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, none required", m_data, m_last);
        end else begin
          eb = exp_q.pop_front();
          chk("beat_data", m_data, eb.d);
          chk("beat_last", m_last, eb.l);
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h, none required", result);
        end else begin
          er = res_q.pop_front();
          chk("result", result, er.d);
          chk("result_count", result_count, er.cnt);
          chk("proto_err", proto_err, er.perr);
          chk("busy_after_result", busy, 0);
        end
      end
    end
    pv = rst_n && m_valid;
    pr = m_ready;
    pd = m_data;
    pl = m_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ld_wren = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_result_count", result_count, 0);
    exp_q.delete();
    res_q.delete();
    perr_m = 1'b0;
    cnt_m = '0;
    res_m = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_image(input bit ramp);
    for (int i = 0; i < N; i++) begin
      ld_wren = 1'b1;
      ld_addr = AW'(i);
      ld_data = ramp ? DW'(i) : DW'($urandom);
      img[i] = ld_data;
      tick();
    end
    ld_wren = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggling 1/0, 2: random ready.
  task automatic run_packet(input int mode, input bit pre, input logic [DW-1:0] rd, input bit rl,
                            input bit disturb, input bit same_wr);
    int cyc;
    bit done;
    int a;
    chk("idle_busy", busy, 0);
    chk("idle_proto_err", proto_err, perr_m);
    start = 1'b1;
    if (same_wr) begin
      a = $urandom_range(N-1, 0);
      ld_wren = 1'b1;
      ld_addr = AW'(a);
      ld_data = DW'($urandom);
      img[a] = ld_data;
    end
    perr_m = 1'b0;
    for (int k = 0; k < N; k++) exp_q.push_back(beat_t'{img[k], k == N-1});
    m_ready = 1'b0;
    if (pre) begin
      s_valid = 1'b1;
      s_data = rd;
      s_last = rl;
    end
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      tick();
      cyc++;
      start = 1'b0;
      ld_wren = 1'b0;
      if (cyc == 1) chk("proto_err_cleared", proto_err, 0);
      if (s_ready) done = 1'b1;
      else if (cyc > 4*N + 8) begin
        checks++;
        errors++;
        $display("FAIL packet_timeout: no s_axis_ready after %0d cycles", cyc);
        done = 1'b1;
      end else begin
        m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(1, 0));
        if (disturb && cyc == 3) begin
          start = 1'b1;
          ld_wren = 1'b1;
          ld_addr = AW'($urandom_range(N-1, 0));
          ld_data = DW'($urandom);
        end
      end
    end
    m_ready = 1'b0;
    chk("after_last_m_valid", m_valid, 0);
    if (mode == 0) chk("cycles_ready_high", cyc, N + 1);
    if (mode == 1) chk("cycles_toggle", cyc, 2*N);
    chk("packet_drained", exp_q.size(), 0);
  endtask

  task automatic give_result(input logic [DW-1:0] d, input bit l);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    cnt_m++;
    if (!l) perr_m = 1'b1;
    res_m = d;
    res_q.push_back(res_t'{d, perr_m, cnt_m});
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    bit rl, pre;
    int n;
    int drops;
    do_reset();
    load_image(1'b1);
    run_packet(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    give_result(DW'(7), 1'b1);
    run_packet(1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    give_result(DW'($urandom), 1'b0);
    tick();
    for (int it = 0; it < 6; it++) begin
      if (it % 2 == 0) load_image(1'b0);
      rd = DW'($urandom);
      rl = 1'($urandom_range(1, 0));
      pre = 1'($urandom_range(1, 0));
      run_packet(2, pre, rd, rl, 1'b1, 1'($urandom_range(1, 0)));
      give_result(rd, rl);
    end
    // Reset in the middle of a packet, with ignored start/write during SEND.
    load_image(1'b0);
    start = 1'b1;
    for (int k = 0; k < N; k++) exp_q.push_back(beat_t'{img[k], k == N-1});
    tick();
    start = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      ld_wren = (k == 4);
      ld_addr = '0;
      ld_data = ~img[0];
      tick();
    end
    do_reset();
    run_packet(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef AXIS_IMG_STREAMER_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 10*T) begin
      tick();
      n++;
    end
    chk("timeout_delay", n, T);
    chk("timeout_busy", busy, 0);
    chk("timeout_result_count", result_count, cnt_m);
    chk("timeout_result", result, res_m);
    tick();
    chk("timeout_pulse_width", timeout, 0);
    run_packet(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    give_result(DW'($urandom), 1'b1);
`else
    drops = 0;
    n = 0;
    repeat (1000) begin
      tick();
      if (!busy || timeout) drops++;
    end
    chk("wait_holds_busy", drops, 0);
    give_result(DW'($urandom), 1'b1);
`endif
    repeat (3) tick();
    chk("results_drained", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
